// File: rtl/flash_frame_loader_pkg.sv
// Shared definitions for the flash frame loader.
// Holds the flash READ opcode, the controller state encoding, the pixel
// format constants and the 3-bytes-to-2-pixels packing helpers.
package flash_frame_loader_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         PIX_BITS       = 12;
    localparam int         BYTES_PER_PAIR = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_e;

    // Even pixel of a pair: all of byte 0 plus the high nibble of byte 1.
    function automatic logic [PIX_BITS-1:0] pix_even(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1[7:4]};
    endfunction

    // Odd pixel of a pair: low nibble of byte 1 plus all of byte 2.
    function automatic logic [PIX_BITS-1:0] pix_odd(input logic [3:0] b1_lo, input logic [7:0] b2);
        return {b1_lo, b2};
    endfunction

endpackage

// File: rtl/flash_frame_loader_spi_bit_engine.sv
// SPI mode-0 bit timing generator.
// Ports: clk/rst_n - clock and async active-low reset; run - enables the
// SPI clock (when low the clock is parked low and the phase counter clears);
// spi_clk - registered SPI clock, low for CLK_DIV cycles then high for
// CLK_DIV cycles; bit_end - single-cycle strobe in the last high-phase
// cycle: the edge closing that cycle samples MISO, shifts MOSI and drops
// spi_clk.
module flash_frame_loader_spi_bit_engine
    import flash_frame_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic spi_clk,
    output logic bit_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          last_s;

    assign last_s  = (cnt_q == CW'(CLK_DIV - 1));
    assign bit_end = run & sclk_q & last_s;
    assign spi_clk = sclk_q;

    // Phase counter and clock toggle.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (last_s) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Phase state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/flash_frame_loader.sv
// Copies one 12bpp frame from SPI flash into the frame-buffer write port.
// Ports: clk/rst_n - clock and async active-low reset; start/base_addr -
// load request and flash byte address (latched when accepted); busy/done -
// transfer status and completion pulse; spi_cs/spi_clk/spi_mosi/spi_miso -
// SPI flash pins (mode 0); fb_we/fb_addr/fb_data - frame-buffer write port.
// Sequence: READ opcode + 24-bit address, then NPIX*3/2 data bytes, every
// 3 bytes packed into 2 pixels written at consecutive addresses.
module flash_frame_loader
    import flash_frame_loader_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int FB_AW   = 12,
    parameter int NPIX    = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [23:0]         base_addr,
    output logic                busy,
    output logic                done,
    output logic                spi_cs,
    output logic                spi_clk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic                fb_we,
    output logic [FB_AW-1:0]    fb_addr,
    output logic [PIX_BITS-1:0] fb_data
);

    localparam int PW = FB_AW + 1;
    localparam int TW = $clog2(CLK_DIV + 1);

    state_e              state_q, state_d;
    logic [31:0]         sr_q, sr_d;
    logic [4:0]          cmd_bit_q, cmd_bit_d;
    logic                mosi_q, mosi_d;
    logic                cs_q, cs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [6:0]          byte_sh_q, byte_sh_d;
    logic [2:0]          bit_in_byte_q, bit_in_byte_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          b0_q, b0_d;
    logic [3:0]          b1_lo_q, b1_lo_d;
    logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
    logic                fb_we_q, fb_we_d;
    logic [FB_AW-1:0]    fb_addr_q, fb_addr_d;
    logic [PIX_BITS-1:0] fb_data_q, fb_data_d;
    logic [TW-1:0]       tail_cnt_q, tail_cnt_d;

    logic        run_s, bit_end_s;
    logic [7:0]  byte_s;
    logic [31:0] cmd_word_s;

    assign run_s      = (state_q == CMD) || (state_q == DATA);
    assign byte_s     = {byte_sh_q, spi_miso};
    assign cmd_word_s = {FLASH_CMD_READ, base_addr};

    flash_frame_loader_spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run_s),
        .spi_clk (spi_clk),
        .bit_end (bit_end_s)
    );

    // Next-state, counters and pixel packing.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cmd_bit_d     = cmd_bit_q;
        mosi_d        = mosi_q;
        cs_d          = cs_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        byte_sh_d     = byte_sh_q;
        bit_in_byte_d = bit_in_byte_q;
        byte_idx_d    = byte_idx_q;
        b0_d          = b0_q;
        b1_lo_d       = b1_lo_q;
        pix_cnt_d     = pix_cnt_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        tail_cnt_d    = tail_cnt_q;
        case (state_q)
            IDLE: begin
                // The done cycle is still IDLE; a start there is dropped.
                if (start && !done_q) begin
                    sr_d          = {cmd_word_s[30:0], 1'b0};
                    mosi_d        = cmd_word_s[31];
                    cs_d          = 1'b0;
                    busy_d        = 1'b1;
                    cmd_bit_d     = 5'd0;
                    bit_in_byte_d = 3'd0;
                    byte_idx_d    = 2'd0;
                    pix_cnt_d     = '0;
                    fb_addr_d     = '0;
                    tail_cnt_d    = '0;
                    state_d       = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (bit_end_s) begin
                    if (cmd_bit_q == 5'd31) begin
                        mosi_d  = 1'b0;
                        state_d = DATA;
                    end else begin
                        mosi_d    = sr_q[31];
                        sr_d      = {sr_q[30:0], 1'b0};
                        cmd_bit_d = cmd_bit_q + 5'd1;
                    end
                end else begin
                    state_d = CMD;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    byte_sh_d     = byte_s[6:0];
                    bit_in_byte_d = bit_in_byte_q + 3'd1;
                    if (bit_in_byte_q == 3'd7) begin
                        if (byte_idx_q == 2'd0) begin
                            b0_d       = byte_s;
                            byte_idx_d = 2'd1;
                        end else if (byte_idx_q == 2'd1) begin
                            fb_we_d    = 1'b1;
                            fb_addr_d  = pix_cnt_q[FB_AW-1:0];
                            fb_data_d  = pix_even(b0_q, byte_s);
                            b1_lo_d    = byte_s[3:0];
                            pix_cnt_d  = pix_cnt_q + PW'(1);
                            byte_idx_d = 2'd2;
                        end else begin
                            fb_we_d    = 1'b1;
                            fb_addr_d  = pix_cnt_q[FB_AW-1:0];
                            fb_data_d  = pix_odd(b1_lo_q, byte_s);
                            pix_cnt_d  = pix_cnt_q + PW'(1);
                            byte_idx_d = 2'(BYTES_PER_PAIR - 3);
                            // Last byte of the last pair closes the frame.
                            if (pix_cnt_q == PW'(NPIX - 1)) begin
                                tail_cnt_d = '0;
                                state_d    = TAIL;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            TAIL: begin
                // CLK_DIV cycles with spi_clk low, one cycle with CS high,
                // then the done pulse.
                if (tail_cnt_q == TW'(CLK_DIV)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tail_cnt_d = tail_cnt_q + TW'(1);
                    if (tail_cnt_q == TW'(CLK_DIV - 1)) begin
                        cs_d = 1'b1;
                    end else begin
                        cs_d = cs_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sr_q          <= 32'd0;
            cmd_bit_q     <= 5'd0;
            mosi_q        <= 1'b0;
            cs_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            byte_sh_q     <= 7'd0;
            bit_in_byte_q <= 3'd0;
            byte_idx_q    <= 2'd0;
            b0_q          <= 8'd0;
            b1_lo_q       <= 4'd0;
            pix_cnt_q     <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            tail_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cmd_bit_q     <= cmd_bit_d;
            mosi_q        <= mosi_d;
            cs_q          <= cs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            byte_sh_q     <= byte_sh_d;
            bit_in_byte_q <= bit_in_byte_d;
            byte_idx_q    <= byte_idx_d;
            b0_q          <= b0_d;
            b1_lo_q       <= b1_lo_d;
            pix_cnt_q     <= pix_cnt_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            tail_cnt_q    <= tail_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;

endmodule
